axi_write_arbiter: RTL and testbench
====================================

// Module: axi_write_arbiter
// PURPOSE
//   Round-robin arbiter for the write path of the 2-master x 2-slave interconnect.
//   Grants one master the AW channel, then locks the W channel until the WLAST handshake,
//   then locks the B channel until the response handshake.
//   Sits beside the read-address arbiter; the interconnect muxes use its grant/sel outputs.
// PARAMETERS
//   ADDR_WIDTH   32  address width; slave decode = addr[ADDR_WIDTH-1] (0 -> S0, 1 -> S1)
//   TIMEOUT      256 max cycles waiting in DATA or RESP before abort; 0 disables watchdog
// PORTS
//   clk          in   1           single clock, all logic on posedge
//   rst          in   1           synchronous, active-high reset
//   M0_AWrequest in   1           master 0 requests a write transaction (held until granted AW handshake)
//   M0_AWaddr    in   ADDR_WIDTH  master 0 write address
//   M1_AWrequest in   1           master 1 request
//   M1_AWaddr    in   ADDR_WIDTH  master 1 write address
//   AWhs         in   1           AW valid&ready handshake on the granted path this cycle
//   Wlast_hs     in   1           W handshake with WLAST=1 on the granted path this cycle
//   Bhs          in   1           B valid&ready handshake on the granted path this cycle
//   M0_AWgrant   out  1           master 0 owns AW channel
//   M1_AWgrant   out  1           master 1 owns AW channel
//   M0_Wgrant    out  1           master 0 owns W channel
//   M1_Wgrant    out  1           master 1 owns W channel
//   M0_Bgrant    out  1           master 0 owns B channel
//   M1_Bgrant    out  1           master 1 owns B channel
//   wsel         out  1           slave index routed for the current transaction (latched at grant)
//   owner        out  1           index of the master holding the transaction
//   busy         out  1           1 in any state other than IDLE
//   timeout_err  out  1           one-cycle pulse on watchdog abort
// BEHAVIOUR
//   Reset: state=IDLE, all grants 0, wsel=0, owner=0, busy=0, timeout_err=0, counter=0;
//     the round-robin pointer is set so M0 wins the first contended cycle. Reset overrides any
//     in-flight transaction; no grant survives the reset cycle.
//   FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE. All outputs are registered; at most one grant is high.
//   IDLE: if any AWrequest is high, pick a winner and register it:
//     - only one requester: it wins;
//     - both requesting: the master not served last wins (round-robin).
//     Next cycle: state=ADDR, Mx_AWgrant=1, owner=x, wsel=decode(Mx_AWaddr) sampled in IDLE.
//     Request-to-grant latency is 1 cycle.
//   ADDR: hold AWgrant.
//     - AWhs=1: next cycle AWgrant=0, Wgrant(owner)=1, state=DATA.
//     - owner AWrequest drops with AWhs=0: abort; next cycle all grants 0, state=IDLE,
//       pointer marks owner as served.
//     - Wlast_hs and Bhs are ignored in ADDR.
//   DATA: hold Wgrant. Wlast_hs=1: next cycle Wgrant=0, Bgrant(owner)=1, state=RESP. Bhs ignored.
//   RESP: hold Bgrant. Bhs=1: next cycle Bgrant=0, state=IDLE, pointer marks owner as served.
//   Back-to-back: after RESP exits, at least one IDLE cycle occurs before the next AWgrant.
//   wsel and owner hold their values from grant until the next grant; they are not cleared in IDLE.
//   Watchdog (TIMEOUT>0):
//     - 8-bit-min counter, width $clog2(TIMEOUT+1); cleared on entry to DATA and RESP;
//       increments each cycle in DATA/RESP without the exit handshake.
//     - When counter == TIMEOUT-1 and no exit handshake occurs: next cycle all grants 0,
//       state=IDLE, timeout_err=1 for one cycle, pointer marks owner as served.
//     - An exit handshake on the same cycle as expiry takes priority: normal transition, no error.
//     - The counter saturates and never wraps.
//   busy = (state != IDLE), registered alongside state.
// TESTING
//   1. Reset, M0_AWrequest=1, addr=0x8000_0000 -> cycle+1 M0_AWgrant=1, wsel=1, owner=0, busy=1.
//   2. Both request continuously, each txn AWhs, Wlast_hs, Bhs one cycle apart ->
//      owners alternate 0,1,0,1; each AWgrant follows RESP exit by exactly 2 cycles.
//   3. M1 granted in ADDR, M1_AWrequest drops before AWhs -> cycle+1 grants 0, IDLE;
//      pending M0 granted the cycle after.
//   4. TIMEOUT=4, enter DATA, no Wlast_hs -> 4 cycles of Wgrant, then grants 0,
//      timeout_err pulses 1 cycle, busy=0.
//   5. TIMEOUT=4, Wlast_hs on the expiry cycle -> Bgrant=1 next cycle, timeout_err stays 0.
//   6. rst=1 while in RESP with M1_Bgrant=1 -> next cycle all outputs 0; M0 and M1 request
//      after release -> M0 wins.

Source files
------------

// File: rtl/axi_write_arbiter.sv
// Round-robin write-path arbiter for a 2-master interconnect: grants AW, then locks W until
// the WLAST handshake, then B until the response handshake, with an optional watchdog.
module axi_write_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  M0_AWrequest,
  input  logic [ADDR_WIDTH-1:0] M0_AWaddr,
  input  logic                  M1_AWrequest,
  input  logic [ADDR_WIDTH-1:0] M1_AWaddr,
  input  logic                  AWhs,
  input  logic                  Wlast_hs,
  input  logic                  Bhs,
  output logic                  M0_AWgrant,
  output logic                  M1_AWgrant,
  output logic                  M0_Wgrant,
  output logic                  M1_Wgrant,
  output logic                  M0_Bgrant,
  output logic                  M1_Bgrant,
  output logic                  wsel,
  output logic                  owner,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            wsel_q, wsel_d;
  logic            last_q, last_d;  // master served most recently
  logic            terr_q, terr_d;
  logic            busy_q, busy_d;
  logic [1:0]      awg_q, awg_d;
  logic [1:0]      wg_q, wg_d;
  logic [1:0]      bg_q, bg_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [1:0] req;
  logic       win;
  logic       expire;
  logic [CntW-1:0] cnt_inc;

  assign req     = {M1_AWrequest, M0_AWrequest};
  assign win     = (&req) ? ~last_q : M1_AWrequest;
  assign expire  = (TIMEOUT != 0) && (cnt_q == CntLast);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wsel_d  = wsel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    awg_d   = 2'b00;
    wg_d    = 2'b00;
    bg_d    = 2'b00;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d     = StAddr;
          owner_d     = win;
          wsel_d      = win ? M1_AWaddr[ADDR_WIDTH-1] : M0_AWaddr[ADDR_WIDTH-1];
          awg_d[win]  = 1'b1;
        end
      end
      StAddr: begin
        if (AWhs) begin
          state_d        = StData;
          wg_d[owner_q]  = 1'b1;
          cnt_d          = '0;
        end else if (!req[owner_q]) begin
          state_d = StIdle;
          last_d  = owner_q;
        end else begin
          awg_d[owner_q] = 1'b1;
        end
      end
      StData: begin
        if (Wlast_hs) begin
          state_d       = StResp;
          bg_d[owner_q] = 1'b1;
          cnt_d         = '0;
        end else if (expire) begin
          state_d = StIdle;
          terr_d  = 1'b1;
          last_d  = owner_q;
        end else begin
          wg_d[owner_q] = 1'b1;
          cnt_d         = cnt_inc;
        end
      end
      StResp: begin
        if (Bhs) begin
          state_d = StIdle;
          last_d  = owner_q;
        end else if (expire) begin
          state_d = StIdle;
          terr_d  = 1'b1;
          last_d  = owner_q;
        end else begin
          bg_d[owner_q] = 1'b1;
          cnt_d         = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      wsel_q  <= 1'b0;
      last_q  <= 1'b1;  // M0 wins the first contended cycle
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      busy_q  <= 1'b0;
      awg_q   <= 2'b00;
      wg_q    <= 2'b00;
      bg_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wsel_q  <= wsel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      busy_q  <= busy_d;
      awg_q   <= awg_d;
      wg_q    <= wg_d;
      bg_q    <= bg_d;
    end
  end

  assign M0_AWgrant  = awg_q[0];
  assign M1_AWgrant  = awg_q[1];
  assign M0_Wgrant   = wg_q[0];
  assign M1_Wgrant   = wg_q[1];
  assign M0_Bgrant   = bg_q[0];
  assign M1_Bgrant   = bg_q[1];
  assign wsel        = wsel_q;
  assign owner       = owner_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Scoreboard bench for axi_write_arbiter: a transaction-level model predicts every cycle's
// outputs into a queue, and a negedge monitor compares them against the DUT.
module tb_axi_write_arbiter;

  localparam int AW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          awhs, wlast_hs, bhs;
  logic          m0_awg, m1_awg, m0_wg, m1_wg, m0_bg, m1_bg;
  logic          wsel, owner, busy, terr;

  axi_write_arbiter #(
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .M0_AWrequest(m0_req),
    .M0_AWaddr   (m0_addr),
    .M1_AWrequest(m1_req),
    .M1_AWaddr   (m1_addr),
    .AWhs        (awhs),
    .Wlast_hs    (wlast_hs),
    .Bhs         (bhs),
    .M0_AWgrant  (m0_awg),
    .M1_AWgrant  (m1_awg),
    .M0_Wgrant   (m0_wg),
    .M1_Wgrant   (m1_wg),
    .M0_Bgrant   (m0_bg),
    .M1_Bgrant   (m1_bg),
    .wsel        (wsel),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (terr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [9:0] exp_q[$];

  // Transaction-level reference: phase of the single outstanding transaction.
  localparam int PhNone = 0, PhAddr = 1, PhData = 2, PhResp = 3;
  int phase = PhNone;
  int m_owner = 0, m_wsel = 0, m_last = 1, m_age = 0;
  bit m_terr = 0;

  function automatic logic [9:0] predict();
    logic [9:0] v;
    v = '0;
    // {m0_awg, m1_awg, m0_wg, m1_wg, m0_bg, m1_bg, wsel, owner, busy, terr}
    v[9] = (phase == PhAddr) && (m_owner == 0);
    v[8] = (phase == PhAddr) && (m_owner == 1);
    v[7] = (phase == PhData) && (m_owner == 0);
    v[6] = (phase == PhData) && (m_owner == 1);
    v[5] = (phase == PhResp) && (m_owner == 0);
    v[4] = (phase == PhResp) && (m_owner == 1);
    v[3] = m_wsel[0];
    v[2] = m_owner[0];
    v[1] = (phase != PhNone);
    v[0] = m_terr;
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        phase = PhNone; m_owner = 0; m_wsel = 0; m_last = 1; m_age = 0; m_terr = 0;
      end else begin
        m_terr = 0;
        case (phase)
          PhNone: if (m0_req || m1_req) begin
            if (m0_req && m1_req) m_owner = 1 - m_last;
            else                  m_owner = m1_req ? 1 : 0;
            m_wsel = (m_owner == 1) ? int'(m1_addr[AW-1]) : int'(m0_addr[AW-1]);
            phase  = PhAddr;
          end
          PhAddr: begin
            if (awhs) begin
              phase = PhData; m_age = 0;
            end else if (!((m_owner == 0) ? m0_req : m1_req)) begin
              phase = PhNone; m_last = m_owner;
            end
          end
          default: begin
            if ((phase == PhData) ? wlast_hs : bhs) begin
              if (phase == PhData) begin phase = PhResp; m_age = 0; end
              else begin phase = PhNone; m_last = m_owner; end
            end else if (m_age >= TO - 1) begin
              phase = PhNone; m_terr = 1; m_last = m_owner;
            end else begin
              m_age++;
            end
          end
        endcase
      end
      exp_q.push_back(predict());
    end
  end

  initial begin
    logic [9:0] exp_v, got_v;
    forever begin
      @(negedge clk);
      cycle++;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {m0_awg, m1_awg, m0_wg, m1_wg, m0_bg, m1_bg, wsel, owner, busy, terr};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %b required %b (awg0 awg1 wg0 wg1 bg0 bg1 wsel owner busy terr)",
                   cycle, got_v, exp_v);
        end
      end
    end
  end

  task automatic step(input bit r0, input bit r1, input bit ha, input bit hw, input bit hb);
    m0_req = r0; m1_req = r1; awhs = ha; wlast_hs = hw; bhs = hb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 0; m1_req = 0; awhs = 0; wlast_hs = 0; bhs = 0;
    m0_addr = 32'h8000_0000; m1_addr = 32'h0000_1000;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst = 1'b0;

    // Single M0 request to the upper slave, completed normally
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Continuous contention: owners alternate
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 0);
      step(1, 1, 1, 0, 0);
      step(1, 1, 0, 1, 0);
      step(1, 1, 0, 0, 1);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // M1 aborts in ADDR while M0 waits
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Watchdog expiry in DATA
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (6) step(0, 0, 0, 0, 0);

    // WLAST on the expiry cycle wins over the watchdog
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Reset while M1 holds B; M0 wins the first contention afterwards
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    rst = 1'b1;
    step(1, 1, 0, 0, 0);
    rst = 1'b0;
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r0, r1;
      r0 = m0_req ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) == 0);
      r1 = m1_req ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 2) == 0);
      m0_addr = $urandom;
      m1_addr = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      step(r0, r1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0);
    end
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
